alu_result_stage: RTL
=====================

# alu_result_stage

Consumer end of the ALU operand-unit outputs: takes the eight parallel WIDTH-bit unit results (bigMuxIn0..bigMuxIn7; slot 3 is the bitwise-AND unit output) plus a 3-bit opcode, selects one, derives zero/negative flags, and delivers it through a 2-entry registered output buffer with valid/ready handshakes on both sides. Sits between the ALU functional units and the register-file writeback. It also keeps a running count of accepted operations.

## Interface
- WIDTH, 16, data width of every mux input and of result.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- bigMuxIn0..bigMuxIn7  in  WIDTH each  functional-unit results; index equals opcode (bigMuxIn3 = AND result).
- opcode  in  3  selects bigMuxIn[opcode]; sampled only on accept.
- in_valid  in  1  upstream presents opcode + operands.
- in_ready  out  1  stage can accept this cycle.
- result  out  WIDTH  head-entry selected value.
- flag_zero  out  1  head entry result == 0.
- flag_neg  out  1  head entry result[WIDTH-1].
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head this cycle.
- op_count  out  16  number of accepted operations, mod 2^16.

## Operation
- Storage: two entries {result, flag_zero, flag_neg}, head/tail order; occupancy count 0..2 held as state EMPTY(0), ONE(1), FULL(2).
- Accept (push) = in_valid & in_ready. Value pushed = bigMuxIn[opcode]; flags computed from that value at push time.
- Pop = out_valid & out_ready.
- in_ready = rst_n & (state != FULL). Depends only on registered state; no combinational path from out_ready or in_valid.
- out_valid = (state != EMPTY). result/flags show head entry; held stable while out_valid & ~out_ready.
- Transitions: EMPTY+push -> ONE; ONE+push only -> FULL; ONE+pop only -> EMPTY; ONE+push+pop -> ONE (new value becomes head next cycle); FULL+pop -> ONE (second entry becomes head); FULL never pushes (in_ready=0). Pop in EMPTY impossible (out_valid=0); out_ready ignored.
- op_count increments by 1 on each push; wraps 16'hFFFF -> 16'h0000.
- Reset (rst_n=0 at a clock edge), including mid-stream: state=EMPTY, both entries and result=0, flag_zero=0, flag_neg=0, out_valid=0, op_count=0; buffered data discarded; a push presented in the reset cycle is dropped. in_ready=0 while rst_n low.

## Timing
- Latency: push at edge N -> out_valid=1 with that value after edge N (visible cycle N+1) if buffer was EMPTY.
- Throughput: 1 op/cycle sustained when out_ready held high.
- With out_ready low: two pushes fill buffer; in_ready drops the cycle after the second push.
- Order strictly FIFO; no entry lost or duplicated across any push/pop combination.
- flag_zero/flag_neg always correspond to the currently displayed result.

## Test plan
- Reset: hold rst_n=0 two cycles with in_valid=1 -> out_valid=0, in_ready=0, result=0, op_count=0; release -> in_ready=1 next cycle.
- Select/flags: bigMuxIn3=16'h00F0, bigMuxIn0=16'h8001, others distinct; push opcode 3 then 0 with out_ready=1 -> result 16'h00F0 (zero=0,neg=0), then 16'h8001 (neg=1); opcode 3 with bigMuxIn3=0 -> flag_zero=1.
- Backpressure: out_ready=0, push A,B -> in_ready=0 after second push, result=A held; third in_valid not accepted; out_ready=1 -> A, then B, then out_valid=0; op_count=2.
- Simultaneous push+pop in ONE: push stream 1..8 with out_ready=1 every cycle -> outputs 1..8 in order, one per cycle, occupancy stays ONE.
- Mid-stream reset: FULL with A,B, assert rst_n=0 one cycle -> out_valid=0, op_count=0, A/B never appear afterwards.
- Counter wrap: 65537 accepted pushes -> op_count=1.

Source files
------------

// File: rtl/alu_result_stage.sv
// alu_result_stage: selects one of eight ALU unit results by opcode, tags it with zero/negative
// flags and hands it downstream through a 2-entry registered valid/ready buffer.
module alu_result_stage #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bigMuxIn0,
  input  logic [WIDTH-1:0] bigMuxIn1,
  input  logic [WIDTH-1:0] bigMuxIn2,
  input  logic [WIDTH-1:0] bigMuxIn3,
  input  logic [WIDTH-1:0] bigMuxIn4,
  input  logic [WIDTH-1:0] bigMuxIn5,
  input  logic [WIDTH-1:0] bigMuxIn6,
  input  logic [WIDTH-1:0] bigMuxIn7,
  input  logic [2:0]       opcode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_neg,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      op_count
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, stateNext;
  logic [WIDTH-1:0] muxIn [8];
  logic [WIDTH-1:0] selVal;
  // entry layout: {neg, zero, value}; flags are frozen at push time
  logic [WIDTH+1:0] headEntry, tailEntry, newEntry, headNext, tailNext;
  logic push, pop;
  assign muxIn = '{bigMuxIn0, bigMuxIn1, bigMuxIn2, bigMuxIn3, bigMuxIn4, bigMuxIn5, bigMuxIn6, bigMuxIn7};
  assign selVal = muxIn[opcode];
  assign newEntry = {selVal[WIDTH-1], selVal == '0, selVal};
  assign in_ready = rst_n & (state != FULL);
  assign out_valid = state != EMPTY;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  assign {flag_neg, flag_zero, result} = headEntry;
  always_comb begin
    stateNext = state;
    headNext = headEntry;
    tailNext = tailEntry;
    case (state)
      EMPTY: if (push) begin
        stateNext = ONE;
        headNext = newEntry;
      end
      ONE: begin
        if (push & pop) headNext = newEntry;
        else if (push) begin
          stateNext = FULL;
          tailNext = newEntry;
        end else if (pop) stateNext = EMPTY;
      end
      FULL: if (pop) begin
        stateNext = ONE;
        headNext = tailEntry;
      end
      default: stateNext = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= EMPTY;
      headEntry <= '0;
      tailEntry <= '0;
      op_count <= '0;
    end else begin
      state <= stateNext;
      headEntry <= headNext;
      tailEntry <= tailNext;
      op_count <= op_count + 16'(push);
    end
  end
endmodule
